postnorm32: RTL and testbench

Post-normalisation and packing stage for the single-precision adder datapath. It sits after the aligned-mantissa add/subtract and takes a raw 27-bit sum with a carry bit, a hidden bit, 23 fraction bits, a guard bit and a sticky bit. It renormalises the sum one bit per cycle: a right shift on carry-out, or left shifts on leading zeros. It then rounds to nearest-even and emits a packed IEEE-754 word with a done flag and exception flags.

---
 rtl/fp32_pkg.sv | 18 +
 rtl/postnorm32_if.sv | 19 +
 rtl/postnorm_round.sv | 20 ++
 rtl/postnorm32.sv | 93 +++++++++
 tb/tb_postnorm32.sv | 215 +++++++++++++++++++++
 5 files changed

// File: rtl/fp32_pkg.sv
// fp32_pkg: shared single-precision constants, normaliser FSM states and word packing helper
package fp32_pkg;
  localparam int EXP_BIAS = 127;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam int FRAC_W = 23;
  localparam int MW = 27;
  localparam int SIGN_POS = 31;
  localparam int EXP_LSB = FRAC_W;
  typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
  function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [FRAC_W-1:0] f);
    logic [31:0] w;
    w = '0;
    w[SIGN_POS] = s;
    w[EXP_LSB +: 8] = e;
    w[FRAC_W-1:0] = f;
    return w;
  endfunction
endpackage

// File: rtl/postnorm32_if.sv
// postnorm32_if: load/operand inputs and packed result/status outputs of the post-normaliser
interface postnorm32_if #(
  parameter int MW = 27,
  parameter int EW = 8
);
  logic en;
  logic load;
  logic sign;
  logic [MW-1:0] M;
  logic [EW-1:0] eS;
  logic [31:0] R;
  logic done;
  logic busy;
  logic OVF;
  logic UNF;
  logic ZF;
  modport master (output en, load, sign, M, eS, input R, done, busy, OVF, UNF, ZF);
  modport slave (input en, load, sign, M, eS, output R, done, busy, OVF, UNF, ZF);
endinterface

// File: rtl/postnorm_round.sv
// postnorm_round: round-to-nearest-even on a normalised mantissa with exponent bump and overflow detect
module postnorm_round
  import fp32_pkg::*;
(
  input  logic [MW-2:0]     n,
  input  logic [7:0]        e,
  output logic [FRAC_W-1:0] frac,
  output logic [7:0]        exp,
  output logic              ovf
);
  logic inc, fc, c;
  logic [7:0] e_inc;
  assign inc = n[1] & (n[0] | n[2]);
  // a fraction carry only wraps the whole mantissa when the hidden bit is set
  assign {fc, frac} = {1'b0, n[MW-3:2]} + {{FRAC_W{1'b0}}, inc};
  assign c = fc & n[MW-2];
  assign e_inc = e + 1'b1;
  assign exp = c ? e_inc : e;
  assign ovf = c && e_inc == EXP_MAX;
endmodule

// File: rtl/postnorm32.sv
// postnorm32: bit-serial renormalise of an fp32 adder sum, then RNE round and IEEE-754 pack
module postnorm32 #(
  parameter int MW = fp32_pkg::MW,
  parameter int EW = 8
) (
  input logic clk,
  input logic rst,
  postnorm32_if.slave bus
);
  import fp32_pkg::*;
  state_t st, st_nx;
  logic [MW-1:0] n, n_nx;
  logic [EW-1:0] e, e_nx, e_inc, rexp;
  logic s, s_nx, ovf, ovf_nx, unf, unf_nx, zf, zf_nx, rovf;
  logic [31:0] r, r_nx;
  logic [FRAC_W-1:0] rfrac;
  assign e_inc = e + 1'b1;
  postnorm_round u_round (.n(n[MW-2:0]), .e(e), .frac(rfrac), .exp(rexp), .ovf(rovf));
  always_comb begin
    st_nx = st;
    n_nx = n;
    e_nx = e;
    s_nx = s;
    r_nx = r;
    ovf_nx = ovf;
    unf_nx = unf;
    zf_nx = zf;
    if (bus.load) begin
      st_nx = NORM;
      n_nx = bus.M;
      e_nx = bus.eS;
      s_nx = bus.sign;
      ovf_nx = 1'b0;
      unf_nx = 1'b0;
      zf_nx = 1'b0;
    end else if (st == NORM) begin
      if (n == '0) begin
        r_nx = pack(s, '0, '0);
        zf_nx = 1'b1;
        st_nx = DONE;
      end else if (n[MW-1]) begin
        // right shift keeps the dropped bit alive in sticky
        n_nx = {1'b0, n[MW-1:2], n[1] | n[0]};
        e_nx = e_inc;
        if (e_inc == EXP_MAX) begin
          r_nx = pack(s, EXP_MAX, '0);
          ovf_nx = 1'b1;
          st_nx = DONE;
        end
      end else if (!n[MW-2] && e > EW'(1)) begin
        n_nx = n << 1;
        e_nx = e - 1'b1;
      end else if (!n[MW-2]) begin
        r_nx = pack(s, '0, '0);
        unf_nx = 1'b1;
        st_nx = DONE;
      end else begin
        st_nx = ROUND;
      end
    end else if (st == ROUND) begin
      r_nx = pack(s, rexp, rfrac);
      ovf_nx = rovf;
      st_nx = DONE;
    end
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st <= IDLE;
      n <= '0;
      e <= '0;
      s <= 1'b0;
      r <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
      zf <= 1'b0;
    end else if (bus.en) begin
      st <= st_nx;
      n <= n_nx;
      e <= e_nx;
      s <= s_nx;
      r <= r_nx;
      ovf <= ovf_nx;
      unf <= unf_nx;
      zf <= zf_nx;
    end
  end
  assign bus.R = r;
  assign bus.done = st == DONE;
  assign bus.busy = st == NORM || st == ROUND;
  assign bus.OVF = ovf;
  assign bus.UNF = unf;
  assign bus.ZF = zf;
endmodule

// File: tb/tb_postnorm32.sv
// tb_postnorm32: directed vectors for postnorm32, checked every cycle against an arithmetic model
module tb_postnorm32;
  logic clk = 0;
  logic rst = 0;
  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;
  logic active = 0;
  logic xd;
  int cnt = 0;
  int lat = 0;
  logic [31:0] res_r = 0;
  logic [31:0] r_hold = 0;
  logic [2:0] res_f = 0;
  postnorm32_if bus ();
  postnorm32 dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", nm, got, want);
    end
  endtask
  // result, {OVF,UNF,ZF} and edges-after-load from the value-level rules
  function automatic void model(input logic sg, input logic [26:0] m, input int es,
                                output logic [31:0] r, output logic [2:0] f, output int l);
    logic [26:0] mm;
    int e, k, mant;
    f = 3'b000;
    r = {sg, 31'b0};
    l = 0;
    mm = m;
    e = es;
    k = 0;
    if (m == 0) begin
      f = 3'b001;
      l = 1;
      return;
    end
    if (m[26]) begin
      e = es + 1;
      if (e == 255) begin
        r = {sg, 8'hFF, 23'b0};
        f = 3'b100;
        l = 1;
        return;
      end
      mm = (m >> 1) | {26'b0, m[0]};
      l = 3;
    end else begin
      while (!mm[25]) begin
        mm = mm << 1;
        k++;
      end
      if (es - k < 1) begin
        f = 3'b010;
        l = (es > 1 ? es - 1 : 0) + 1;
        return;
      end
      e = es - k;
      l = k + 2;
    end
    mant = int'(mm[25:2]) + ((mm[1] && (mm[0] || mm[2])) ? 1 : 0);
    if (mant == (1 << 24)) begin
      mant = 1 << 23;
      e++;
    end
    if (e == 255) f = 3'b100;
    r = {sg, 8'(e), 23'(mant)};
  endfunction
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      active = 0;
      r_hold = 0;
      cnt = 0;
    end else if (bus.en) begin
      if (bus.load) begin
        if (active && cnt >= lat) r_hold = res_r;
        model(bus.sign, bus.M, int'(bus.eS), res_r, res_f, lat);
        cnt = 0;
        active = 1;
      end else if (active && cnt < lat) begin
        cnt++;
      end
    end
  end
  always @(negedge clk) begin
    if (chk_on) begin
      xd = active && cnt >= lat;
      chk("done", bus.done, xd);
      chk("busy", bus.busy, active && !xd);
      chk("R", bus.R, xd ? res_r : r_hold);
      chk("flags", {bus.OVF, bus.UNF, bus.ZF}, xd ? res_f : 3'b000);
    end
  end
  task automatic wait_done(output int c);
    c = 0;
    while (!bus.done && c < 60) begin
      @(posedge clk);
      #2;
      c++;
    end
  endtask
  task automatic run(input string nm, input logic sg, input logic [26:0] m, input logic [7:0] es,
                     input logic [31:0] xr, input logic [2:0] xf, input int xl);
    int c;
    @(posedge clk);
    #2;
    bus.load = 1;
    bus.sign = sg;
    bus.M = m;
    bus.eS = es;
    @(posedge clk);
    #2;
    bus.load = 0;
    wait_done(c);
    chk({nm, "_lat"}, c, xl);
    chk({nm, "_R"}, bus.R, xr);
    chk({nm, "_flags"}, {bus.OVF, bus.UNF, bus.ZF}, xf);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int c;
    bus.en = 1;
    bus.load = 0;
    bus.sign = 0;
    bus.M = '0;
    bus.eS = '0;
    @(posedge clk);
    #2 chk_on = 1;
    @(posedge clk);
    #2;
    chk("rst_R", bus.R, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_flags", {bus.OVF, bus.UNF, bus.ZF}, 0);
    rst = 1;
    run("one_plus_one", 0, 27'h4000000, 127, 32'h40000000, 3'b000, 3);
    run("left_norm", 0, 27'h0400000, 130, 32'h3F800000, 3'b000, 5);
    run("round_wrap", 0, 27'h3FFFFFE, 127, 32'h40000000, 3'b000, 2);
    run("tie_even", 0, 27'h2000002, 127, 32'h3F800000, 3'b000, 2);
    run("tie_odd", 0, 27'h2000006, 127, 32'h3F800002, 3'b000, 2);
    run("carry_sticky", 0, 27'h4000005, 127, 32'h40000001, 3'b000, 3);
    run("ovf_carry", 0, 27'h4000000, 254, 32'h7F800000, 3'b100, 1);
    run("ovf_round", 1, 27'h3FFFFFE, 254, 32'hFF800000, 3'b100, 2);
    run("unf", 1, 27'h0400000, 2, 32'h80000000, 3'b010, 2);
    run("unf_e1", 0, 27'h1000000, 1, 32'h00000000, 3'b010, 1);
    run("min_norm", 0, 27'h2000000, 1, 32'h00800000, 3'b000, 2);
    run("zero", 1, 27'h0000000, 100, 32'h80000000, 3'b001, 1);
    run("worst_shift", 0, 27'h0000002, 150, 32'h3F000000, 3'b000, 26);
    // freeze mid-NORM, with a load offered that must be ignored
    bus.load = 1;
    bus.sign = 0;
    bus.M = 27'h0400000;
    bus.eS = 130;
    @(posedge clk);
    #2 bus.load = 0;
    @(posedge clk);
    #2;
    bus.en = 0;
    bus.load = 1;
    bus.M = '0;
    repeat (5) @(posedge clk);
    #2;
    chk("freeze_busy", bus.busy, 1);
    chk("freeze_done", bus.done, 0);
    chk("freeze_R", bus.R, 32'h3F000000);
    bus.load = 0;
    bus.M = 27'h0400000;
    bus.en = 1;
    wait_done(c);
    chk("freeze_lat", c, 4);
    chk("freeze_result", bus.R, 32'h3F800000);
    // long operation aborted by a new load
    bus.load = 1;
    bus.M = 27'h0000002;
    bus.eS = 150;
    @(posedge clk);
    #2 bus.load = 0;
    repeat (3) @(posedge clk);
    #2;
    run("reload", 0, 27'h4000000, 127, 32'h40000000, 3'b000, 3);
    // reset while in ROUND
    bus.load = 1;
    bus.M = 27'h2000000;
    bus.eS = 127;
    @(posedge clk);
    #2 bus.load = 0;
    @(posedge clk);
    #2;
    chk("round_busy", bus.busy, 1);
    rst = 0;
    #1;
    chk("midrst_R", bus.R, 0);
    chk("midrst_done", bus.done, 0);
    chk("midrst_busy", bus.busy, 0);
    chk("midrst_flags", {bus.OVF, bus.UNF, bus.ZF}, 0);
    @(posedge clk);
    #2 rst = 1;
    @(posedge clk);
    #2;
    chk("post_rst_done", bus.done, 0);
    chk("post_rst_busy", bus.busy, 0);
    run("after_rst", 0, 27'h2000000, 127, 32'h3F800000, 3'b000, 2);
    @(negedge clk);
    #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
